// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run / breakpoint clock-enable controller for a small CPU.
// A debounced manual switch issues single pulses; run mode issues periodic pulses until a PC match.
module cpu_step_ctrl #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 step_sw,
  input  logic                 run_en,
  input  logic [7:0]           rate,
  input  logic                 bp_en,
  input  logic [4:0]           bp_addr,
  input  logic [4:0]           pc,
  output logic                 cpu_en,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStep  = 2'd1,
    StRun   = 2'd2,
    StBreak = 2'd3
  } state_e;

  localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 s1_q, s2_q;
  logic                 deb_q, deb_prev_q, step_req_q;
  logic [7:0]           deb_cnt_q;
  logic [7:0]           div_q, div_d;
  logic                 first_q, first_d;
  logic                 cpu_en_q, cpu_en_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 bp_hit;

  // Synchronizer, debouncer and rising-edge detector on the debounced level.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      step_req_q <= 1'b0;
      deb_cnt_q  <= 8'd0;
    end else begin
      s1_q       <= step_sw;
      s2_q       <= s1_q;
      deb_prev_q <= deb_q;
      step_req_q <= deb_q & ~deb_prev_q;
      if (s2_q == deb_q) begin
        deb_cnt_q <= 8'd0;
      end else if (deb_cnt_q == DebLast) begin
        deb_q     <= s2_q;
        deb_cnt_q <= 8'd0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 8'd1;
      end
    end
  end

  // The first run-mode pulse ignores the breakpoint so a resume at bp_addr moves past it.
  assign bp_hit = bp_en && (pc == bp_addr) && !first_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    first_d  = first_q;
    cpu_en_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_en) begin
          state_d = StRun;
          div_d   = 8'd0;
          first_d = 1'b1;
        end else if (step_req_q) begin
          cpu_en_d = 1'b1;
          state_d  = StStep;
        end
      end
      StStep: begin
        if (!deb_q) state_d = StIdle;
      end
      StRun: begin
        if (!run_en) begin
          state_d = StIdle;
          div_d   = 8'd0;
        end else if (div_q >= rate) begin
          div_d = 8'd0;
          if (bp_hit) begin
            state_d = StBreak;
          end else begin
            cpu_en_d = 1'b1;
            first_d  = 1'b0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StBreak: begin
        if (!run_en) begin
          state_d = StIdle;
        end else if (step_req_q) begin
          cpu_en_d = 1'b1;
          state_d  = StStep;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      div_q    <= 8'd0;
      first_q  <= 1'b0;
      cpu_en_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      first_q  <= first_d;
      cpu_en_q <= cpu_en_d;
      if (cpu_en_d) count_q <= count_q + 1'b1;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign halted      = (state_q == StBreak);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: step, glitch, run, rate change, breakpoint, resume, wrap, reset.
module tb_cpu_step_ctrl;

  logic        clock;
  logic        reset;
  logic        step_sw;
  logic        run_en;
  logic [7:0]  rate;
  logic        bp_en;
  logic [4:0]  bp_addr;
  logic [4:0]  pc;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] instr_count;

  int compared   = 0;
  int mismatched = 0;
  int pulses;
  int first_at;
  int last_at;

  cpu_step_ctrl #(
    .DEB_CYCLES(4),
    .CNT_WIDTH (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step_sw    (step_sw),
    .run_en     (run_en),
    .rate       (rate),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .state      (state),
    .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks, counting cpu_en pulses and the tick indices of the first and last one.
  task automatic run_ticks(input int n, output int cnt, output int first, output int last);
    cnt   = 0;
    first = 0;
    last  = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (cpu_en === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
        last = i;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    step_sw = 1'b0;
    run_en  = 1'b0;
    rate    = 8'd3;
    bp_en   = 1'b0;
    bp_addr = 5'd0;
    pc      = 5'd0;
    tick();
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_count", 32'(instr_count), 0);
    reset = 1'b0;
    tick();

    // Glitch shorter than the debounce window
    step_sw = 1'b1;
    tick(); tick(); tick();
    step_sw = 1'b0;
    run_ticks(12, pulses, first_at, last_at);
    check("glitch_pulses", 32'(pulses), 0);
    check("glitch_count", 32'(instr_count), 0);
    check("glitch_state", 32'(state), 0);

    // Single step: pulse lands on the 8th edge after the switch goes high
    step_sw = 1'b1;
    run_ticks(20, pulses, first_at, last_at);
    check("step_pulses", 32'(pulses), 1);
    check("step_latency", 32'(first_at), 8);
    check("step_state", 32'(state), 1);
    check("step_count", 32'(instr_count), 1);
    step_sw = 1'b0;
    run_ticks(12, pulses, first_at, last_at);
    check("step_release_state", 32'(state), 0);
    check("step_release_pulses", 32'(pulses), 0);

    // Free run, rate=3 -> every 4th clock
    rate   = 8'd3;
    run_en = 1'b1;
    tick();
    check("run_enter_state", 32'(state), 2);
    run_ticks(40, pulses, first_at, last_at);
    check("run3_pulses", 32'(pulses), 10);
    check("run3_first", 32'(first_at), 4);
    check("run3_last", 32'(last_at), 40);
    check("run3_count", 32'(instr_count), 11);
    rate = 8'd0;
    run_ticks(8, pulses, first_at, last_at);
    check("run0_pulses", 32'(pulses), 8);
    check("run0_cpu_en_high", 32'(cpu_en), 1);
    check("run0_count", 32'(instr_count), 19);
    run_en = 1'b0;
    run_ticks(10, pulses, first_at, last_at);
    check("stop_pulses", 32'(pulses), 0);
    check("stop_state", 32'(state), 0);
    check("stop_count", 32'(instr_count), 19);

    // Lowering rate below the running divider fires on the next edge
    rate   = 8'd10;
    run_en = 1'b1;
    tick();
    run_ticks(5, pulses, first_at, last_at);
    check("rate_chg_quiet", 32'(pulses), 0);
    rate = 8'd2;
    tick();
    check("rate_chg_fire", 32'(cpu_en), 1);
    run_en = 1'b0;
    tick();
    check("rate_chg_count", 32'(instr_count), 20);

    // Breakpoint at pc=5, pc advances once per pulse
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_count", 32'(instr_count), 0);
    bp_en   = 1'b1;
    bp_addr = 5'd5;
    pc      = 5'd0;
    rate    = 8'd1;
    run_en  = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 60 && state !== 2'd3; i++) begin
      tick();
      if (cpu_en === 1'b1) begin
        pulses++;
        pc = pc + 5'd1;
      end
    end
    check("bp_pulses", 32'(pulses), 5);
    check("bp_state", 32'(state), 3);
    check("bp_halted", 32'(halted), 1);
    check("bp_count", 32'(instr_count), 5);
    check("bp_cpu_en", 32'(cpu_en), 0);

    // Single step out of BREAK
    step_sw = 1'b1;
    run_ticks(20, pulses, first_at, last_at);
    check("bpstep_pulses", 32'(pulses), 1);
    check("bpstep_state", 32'(state), 1);
    check("bpstep_halted", 32'(halted), 0);
    run_en  = 1'b0;
    step_sw = 1'b0;
    run_ticks(12, pulses, first_at, last_at);
    check("bpstep_release_state", 32'(state), 0);
    check("bpstep_count", 32'(instr_count), 6);

    // Resume at pc=5: first pulse passes the breakpoint, then a branch back re-hits it
    run_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60 && state !== 2'd3; i++) begin
      tick();
      if (cpu_en === 1'b1) begin
        pulses++;
        pc = (pulses == 1) ? 5'd3 : pc + 5'd1;
      end
    end
    check("resume_pulses", 32'(pulses), 3);
    check("resume_state", 32'(state), 3);
    check("resume_count", 32'(instr_count), 9);
    run_en = 1'b0;
    tick();
    check("break_exit_state", 32'(state), 0);
    check("break_exit_halted", 32'(halted), 0);

    // Counter wrap, then reset mid-pulse in RUN
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    bp_en  = 1'b0;
    rate   = 8'd0;
    run_en = 1'b1;
    tick();
    repeat (65535) tick();
    check("wrap_full", 32'(instr_count), 32'hFFFF);
    tick();
    check("wrap_zero", 32'(instr_count), 0);
    check("wrap_cpu_en", 32'(cpu_en), 1);
    reset = 1'b1;
    tick();
    check("runrst_state", 32'(state), 0);
    check("runrst_cpu_en", 32'(cpu_en), 0);
    check("runrst_halted", 32'(halted), 0);
    check("runrst_count", 32'(instr_count), 0);
    reset  = 1'b0;
    run_en = 1'b0;
    tick();
    check("postrst_state", 32'(state), 0);
    check("postrst_cpu_en", 32'(cpu_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles required before the debounced step level changes; legal range 1..255.
REQ-002 Parameter CNT_WIDTH, default 16: width of instr_count.
REQ-003 clock  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 step_sw  input  1: raw, asynchronous manual step switch.
REQ-006 run_en  input  1: free-run mode request.
REQ-007 rate  input  8: run-mode period minus one, in clocks between cpu_en pulses.
REQ-008 bp_en  input  1: breakpoint enable.
REQ-009 bp_addr  input  5: breakpoint PC value.
REQ-010 pc  input  5: current processor PC.
REQ-011 cpu_en  output  1: registered one-cycle clock-enable pulse to the processor.
REQ-012 halted  output  1: high while stopped at a breakpoint.
REQ-013 state  output  2: current FSM state; IDLE=0, STEP=1, RUN=2, BREAK=3.
REQ-014 instr_count  output  CNT_WIDTH: number of cpu_en pulses issued.

Function
REQ-015 step_sw SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-016 Debounce: deb SHALL take s2's value only after s2 has differed from deb for DEB_CYCLES consecutive clocks; any cycle with s2 == deb SHALL clear the counter.
REQ-017 step_req SHALL be a one-cycle internal pulse on each deb 0->1 transition.
REQ-018 cpu_en SHALL be registered, high for exactly one clock per issued pulse (continuously high only when rate=0 in RUN).
REQ-019 IDLE: run_en=1 -> RUN, div cleared, first_pulse flag set; else step_req -> issue pulse, go STEP; run_en SHALL win over a simultaneous step_req (step discarded).
REQ-020 STEP: deb=0 -> IDLE; no further pulses; step_req cannot recur while deb=1.
REQ-021 RUN: run_en=0 -> IDLE with no pulse that cycle and div cleared.
REQ-022 RUN: div increments each cycle; when div >= rate, div clears and a pulse is issued, unless the breakpoint condition holds.
REQ-023 Breakpoint condition: bp_en=1 and pc == bp_addr and first_pulse=0; when true at a pulse point, the FSM SHALL go to BREAK and issue no pulse.
REQ-024 first_pulse SHALL clear on the first pulse issued in RUN, so that resuming at the breakpoint PC advances past it.
REQ-025 A rate change mid-count SHALL take effect on the next comparison; a pulse fires immediately if div >= the new rate.
REQ-026 BREAK: run_en=0 -> IDLE; else step_req -> issue pulse, go STEP; halted = (state == BREAK).
REQ-027 run_en=0 SHALL take priority over every other event in RUN and BREAK.
REQ-028 instr_count SHALL increment by 1 in the cycle cpu_en is high and wrap from all-ones to 0.

Reset
REQ-029 With reset high at a rising edge, the block SHALL load: state=IDLE, cpu_en=0, halted=0, instr_count=0, div=0, first_pulse=0, s1=s2=deb=0, debounce counter=0.
REQ-030 Reset SHALL override all inputs, including mid-pulse, mid-debounce and in BREAK; the first non-reset edge starts from IDLE.

Verification
REQ-031 Step: DEB_CYCLES=4, step_sw 0->1 held 20 clocks -> cpu_en high once, 7 edges after the first edge sampling step_sw=1; state=STEP; instr_count=1; step_sw->0 leads to IDLE after debounce.
REQ-032 Glitch: step_sw high for 3 clocks, then low -> no cpu_en; instr_count=0; state stays IDLE.
REQ-033 Run: run_en=1, rate=3, bp_en=0 -> cpu_en every 4th clock; rate=0 -> cpu_en high every clock; run_en=0 -> no further pulses, state=IDLE.
REQ-034 Breakpoint: bp_en=1, bp_addr=5, pc increments per pulse from 0 -> pulses for pc=0..4, then state=BREAK, halted=1, instr_count=5; a step pulse gives one cpu_en, then STEP, then IDLE on release.
REQ-035 Resume at breakpoint: pc=5=bp_addr, run_en toggled 0->1 -> first pulse issued (pc advances); the next match of pc=5 halts again.
REQ-036 Reset/wrap: instr_count preloaded by 65535 pulses, one more pulse gives 0; reset asserted in RUN mid-count -> all outputs at REQ-029 values on the next edge.
